// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory,
// applies branch/jump redirects (held across stalls) and loads the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rd,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump,
  input  logic [31:0]        jump_target,
  output logic [31:0]        pc,
  output logic [31:0]        instr_d,
  output logic [31:0]        pcplus4_d,
  output logic               valid_d,
  output logic               addr_err,
  output logic               dbg_halt
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_t_q, pend_t_d;
  logic [31:0] instr_q, instr_d_n;
  logic [31:0] pcplus4_q, pcplus4_d_n;
  logic        valid_q, valid_d_n;
  logic        addr_err_q, addr_err_d;

  logic        req;
  logic [31:0] tgt;
  logic        apply_v;
  logic [31:0] apply_t;
  logic [31:0] pc_inc;

  assign req     = jump | branch_taken;
  assign tgt     = jump ? jump_target : branch_target;
  // A fresh request overrides any redirect parked during an earlier stall.
  assign apply_v = (state_q == RUN) && !stall && (req || pend_v_q);
  assign apply_t = req ? tgt : pend_t_q;
  assign pc_inc  = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_t_d   = pend_t_q;
    addr_err_d = addr_err_q;
    if (state_q == RUN) begin
      if (stall) begin
        if (req) begin
          pend_v_d = 1'b1;
          pend_t_d = tgt;
        end
      end else if (apply_v) begin
        pend_v_d = 1'b0;
        if (apply_t[1:0] != 2'b00) begin
          addr_err_d = 1'b1;
          state_d    = HALT;
        end else begin
          pc_d = apply_t;
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_comb begin
    instr_d_n   = instr_q;
    pcplus4_d_n = pcplus4_q;
    valid_d_n   = valid_q;
    if (flush) begin
      instr_d_n   = '0;
      pcplus4_d_n = '0;
      valid_d_n   = 1'b0;
    end else if (state_q == RUN && stall) begin
      instr_d_n   = instr_q;
    end else if (apply_v || state_q == HALT) begin
      // Squash the wrong-path fetch behind a redirect, and fetch nothing once halted.
      instr_d_n   = '0;
      pcplus4_d_n = '0;
      valid_d_n   = 1'b0;
    end else begin
      instr_d_n   = imem_rd;
      pcplus4_d_n = pc_inc;
      valid_d_n   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_t_q   <= '0;
      instr_q    <= '0;
      pcplus4_q  <= '0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_t_q   <= pend_t_d;
      instr_q    <= instr_d_n;
      pcplus4_q  <= pcplus4_d_n;
      valid_q    <= valid_d_n;
      addr_err_q <= addr_err_d;
    end
  end

  // Fetch wraps within the memory; the PC register itself runs the full 32 bits.
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign pc        = pc_q;
  assign instr_d   = instr_q;
  assign pcplus4_d = pcplus4_q;
  assign valid_d   = valid_q;
  assign addr_err  = addr_err_q;
  assign dbg_halt  = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free run, redirects, stalls, flush,
// misaligned target halt, reset recovery and instruction-memory wrap.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rd;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] instr_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic        addr_err;
  logic        dbg_halt;

  int n_vec;
  int n_err;

  logic [31:0] imem [64];

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc),
    .instr_d       (instr_d),
    .pcplus4_d     (pcplus4_d),
    .valid_d       (valid_d),
    .addr_err      (addr_err),
    .dbg_halt      (dbg_halt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rd = imem[imem_addr];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_p4, input logic e_valid);
    check({tag, ".pc"},      pc,        e_pc);
    check({tag, ".instr"},   instr_d,   e_instr);
    check({tag, ".pcplus4"}, pcplus4_d, e_p4);
    check({tag, ".valid"},   {31'b0, valid_d}, {31'b0, e_valid});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 64; k++) imem[k] = 32'h1000_0000 + k;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();

    // Reset state
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check("reset.addr_err", {31'b0, addr_err}, 32'h0);
    check("reset.halt", {31'b0, dbg_halt}, 32'h0);
    check("reset.imem_addr", {26'b0, imem_addr}, 32'h0);

    // Free run: instr_d lags pc by one cycle
    reset = 1'b1;
    tick();
    check_ifid("run1", 32'h4, 32'h1000_0000, 32'h4, 1'b1);
    tick();
    check_ifid("run2", 32'h8, 32'h1000_0001, 32'h8, 1'b1);

    // Branch at pc=0x8 to 0x20
    branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    idle_inputs();
    check_ifid("br.bubble", 32'h20, 32'h0, 32'h0, 1'b0);
    tick();
    check_ifid("br.target", 32'h24, 32'h1000_0008, 32'h24, 1'b1);

    // Jump beats branch
    jump = 1'b1; jump_target = 32'h40;
    branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    idle_inputs();
    check_ifid("jmp.bubble", 32'h40, 32'h0, 32'h0, 1'b0);
    tick();
    check_ifid("jmp.target", 32'h44, 32'h1000_0010, 32'h44, 1'b1);

    // Three-cycle stall with a branch to 0x30 in the second stall cycle
    stall = 1'b1;
    tick();
    check_ifid("stall1", 32'h44, 32'h1000_0010, 32'h44, 1'b1);
    branch_taken = 1'b1; branch_target = 32'h30;
    tick();
    check_ifid("stall2", 32'h44, 32'h1000_0010, 32'h44, 1'b1);
    branch_taken = 1'b0;
    tick();
    check_ifid("stall3", 32'h44, 32'h1000_0010, 32'h44, 1'b1);
    stall = 1'b0;
    tick();
    check_ifid("pend.bubble", 32'h30, 32'h0, 32'h0, 1'b0);
    tick();
    check_ifid("pend.target", 32'h34, 32'h1000_000C, 32'h34, 1'b1);

    // Fresh jump on stall release beats the parked branch
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h50;
    tick();
    check("park.pc", pc, 32'h34);
    idle_inputs();
    jump = 1'b1; jump_target = 32'h60;
    tick();
    idle_inputs();
    check_ifid("fresh.bubble", 32'h60, 32'h0, 32'h0, 1'b0);
    tick();
    check_ifid("fresh.target", 32'h64, 32'h1000_0018, 32'h64, 1'b1);

    // Flush together with stall
    flush = 1'b1; stall = 1'b1;
    tick();
    idle_inputs();
    check_ifid("flush", 32'h64, 32'h0, 32'h0, 1'b0);
    tick();
    check_ifid("after.flush", 32'h68, 32'h1000_0019, 32'h68, 1'b1);

    // Free run across the instruction-memory wrap
    for (int i = 0; i < 37; i++) tick();
    check("wrap.pc_fc", pc, 32'hFC);
    tick();
    check_ifid("wrap.100", 32'h100, 32'h1000_003F, 32'h100, 1'b1);
    check("wrap.imem_addr", {26'b0, imem_addr}, 32'h0);
    tick();
    check_ifid("wrap.104", 32'h104, 32'h1000_0000, 32'h104, 1'b1);

    // Misaligned jump target halts fetch
    jump = 1'b1; jump_target = 32'h22;
    tick();
    idle_inputs();
    check_ifid("mis", 32'h104, 32'h0, 32'h0, 1'b0);
    check("mis.addr_err", {31'b0, addr_err}, 32'h1);
    check("mis.halt", {31'b0, dbg_halt}, 32'h1);
    tick();
    check_ifid("halt1", 32'h104, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    idle_inputs();
    check_ifid("halt.ignore", 32'h104, 32'h0, 32'h0, 1'b0);
    check("halt.addr_err", {31'b0, addr_err}, 32'h1);

    // Reset leaves HALT
    reset = 1'b0;
    tick();
    check_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst2.addr_err", {31'b0, addr_err}, 32'h0);
    check("rst2.halt", {31'b0, dbg_halt}, 32'h0);

    // Reset during a stall discards the parked redirect
    reset = 1'b1;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    check("park2.pc", pc, 32'h0);
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_ifid("rst.discard", 32'h4, 32'h1000_0000, 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that owns the program counter and drives the word address into the 64-entry instruction memory, which returns the instruction combinationally in the same cycle. Selects the next PC from sequential increment, branch, or jump; holds redirects that arrive during a stall; and registers the fetched instruction into the IF/ID pipeline register consumed by decode. Detects misaligned redirect targets and halts fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_AW, 6, instruction-memory word-address width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  IMEM_AW  = pc[IMEM_AW+1:2], combinational from the pc register.
- imem_rd  in  32  instruction word returned for imem_addr, same cycle.
- stall  in  1  hazard-unit hold for PC and IF/ID.
- flush  in  1  turns IF/ID into a bubble.
- branch_taken  in  1  branch redirect request.
- branch_target  in  32  branch destination byte address.
- jump  in  1  jump redirect request; beats branch_taken.
- jump_target  in  32  jump destination byte address.
- pc  out  32  current fetch PC (register).
- instr_d  out  32  IF/ID instruction.
- pcplus4_d  out  32  IF/ID PC+4 of instr_d.
- valid_d  out  1  IF/ID holds a real instruction.
- addr_err  out  1  sticky misaligned-target flag.

## Operation
- Redirect request: req = jump | branch_taken. Target: tgt = jump ? jump_target : branch_target.
- States: RUN, HALT. Reset enters RUN. RUN→HALT on an accepted misaligned target. HALT is left only by reset.
- Pending redirect register (pend_v, pend_t):
  - When stall=1 and req=1, load pend_v=1 and pend_t=tgt.
  - A later request during the same stall overwrites pend_t.
- RUN with stall=0, first match wins:
  - req=1: pc<=tgt and pend_v<=0.
  - pend_v=1: pc<=pend_t and pend_v<=0.
  - Otherwise pc<=pc+4, modulo 2^32.
- RUN with stall=1: pc holds.
- Misalignment check: if the applied target (tgt or pend_t) has bits [1:0]≠00, pc holds, pend_v<=0, addr_err<=1, and the state goes to HALT. The target is never loaded.
- IF/ID update, priority order:
  1. Reset: clear.
  2. flush=1: bubble (instr_d=0, pcplus4_d=0, valid_d=0). Flush beats stall.
  3. stall=1: hold.
  4. A redirect is applied this cycle (from req or pend_v): bubble. This squashes the wrong-path fetch.
  5. HALT: bubble.
  6. Otherwise: instr_d<=imem_rd, pcplus4_d<=pc+4, valid_d<=1.
- HALT: pc holds. The stall, req, and flush inputs are ignored except that flush still forces a bubble.
- Address wrap: imem_addr truncates the PC, so instruction fetch wraps modulo 2^IMEM_AW words (PC 0x100 fetches word 0). The pc register itself does not wrap until 2^32.

## Timing
- Reset values: pc=RESET_PC, instr_d=0, pcplus4_d=0, valid_d=0, addr_err=0, pend_v=0, state=RUN. imem_addr follows from the reset pc.
- Fetch latency:
  - The instruction at pc appears on instr_d one cycle after pc presents it.
  - The first valid_d=1 is in the first cycle after reset is released.
- Redirect latency:
  - A redirect sampled at edge N puts the target on pc after N, a bubble in IF/ID after N, and the target instruction in IF/ID after N+1.
- A redirect arriving during a stall is applied at the first edge with stall=0, with the same bubble behaviour.
- Reset asserted mid-stall or mid-redirect discards pending state on that edge.
- Simultaneous events:
  - jump and branch_taken together: jump wins.
  - A fresh req together with pend_v and stall=0: the fresh req wins and the pending redirect is discarded.

## Test plan
- Reset then free run, with imem word k = 0x1000_0000+k. Required: pc = 0, 4, 8, …; instr_d lags pc by one cycle; valid_d rises on the first cycle after reset.
- branch_taken=1, branch_target=0x20 at pc=0x8. Required: next pc=0x20; IF/ID is a bubble for one cycle; then instr_d = word 8 and pcplus4_d = 0x24.
- jump=1 (0x40) together with branch_taken=1 (0x20). Required: pc=0x40.
- stall=1 for 3 cycles with a branch to 0x30 in the second stall cycle. Required: pc and IF/ID hold; on release pc=0x30 with one bubble.
- flush and stall together. Required: valid_d=0 and instr_d=0 next cycle while pc holds.
- jump_target=0x22. Required: addr_err=1; pc holds; valid_d stays 0 after one cycle; state stays there until reset low, after which pc=RESET_PC and addr_err=0.
- Free run past pc=0xFC. Required: pc=0x100 and imem_addr=0.
